// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory target for the CPU load/store port.
// One request is in flight at a time. IDLE accepts a request, WAIT counts
// LATENCY-1 cycles and then performs the access, and RESP presents the
// response until the requester takes it.
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When it is defined, an
// in-range access whose addr[1:0] is not 2'b00 is reported as an error.
//
// Handshake rules, for both channels: a transfer happens on a rising edge
// where valid and ready are both 1. Once a source raises valid, it holds
// valid and its payload stable until that edge. req_ready is 1 only in
// IDLE. rsp_valid is 1 only in RESP.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic             misaligned;
  logic             access_ok;
  logic [IDX_W-1:0] idx;
  logic             access_now;
  logic             mem_we;
  logic [31:0]      rdata_d;
  logic             err_d;

  // Decode the latched address. The offset is computed with 32-bit
  // wrap-around, so the lower-bound test is needed as well: a low
  // address must not wrap into range.
  always_comb begin
    offset     = addr_q - BASE_ADDR;
    in_range   = (addr_q >= BASE_ADDR) && (offset < SPAN);
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = (addr_q[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    access_ok  = in_range && !misaligned;
    idx        = offset[IDX_W+1:2];
    access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);
    mem_we     = access_now && we_q && access_ok;
    rdata_d    = (access_ok && !we_q) ? mem_q[idx] : 32'd0;
    err_d      = !access_ok;
  end

  // Request/response sequencing. All handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Word storage. Reset clears it, and reset also wins over a store that
  // would have been committed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. It drives directed load/store vectors and
// keeps a word-array model of the storage, plus the expected state of the
// single outstanding response. Each cycle, one compare process checks the
// DUT handshake outputs and response payload against that model. Literal
// expectations for the test-plan vectors pin the model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  dmem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- model ----------------
  logic [31:0] model_mem [DEPTH];
  bit          busy;
  int          due;
  logic [31:0] exp_rdata;
  bit          exp_err;
  bit          pend_store;
  int          pend_idx;
  logic [31:0] pend_wdata;
  logic [3:0]  pend_be;
  bit          chk_en;

  int n_tests;
  int n_fail;

  function automatic bit model_err(input logic [31:0] a);
    longint unsigned la;
    longint unsigned lo;
    longint unsigned hi;
    bit e;
    la = longint'(a);
    lo = longint'(BASE);
    hi = lo + 4 * DEPTH;
    e  = !(la >= lo && la < hi);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (!e && a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = busy && (edge_n >= due);
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
      check("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      if (ev) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    busy       = 1'b0;
    pend_store = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] got_rdata, output logic got_err);
    int t;
    got_rdata = 32'hxxxx_xxxx;
    got_err   = 1'bx;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      do_reset();
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    // Keep offering a junk store while busy: the DUT must ignore it.
    req_we    = 1'b1;
    req_addr  = BASE + 32'h20;
    req_wdata = $urandom;
    req_be    = 4'hF;
    busy      = 1'b1;
    due       = edge_n + LAT;
    exp_err   = model_err(addr);
    exp_rdata = (exp_err || we) ? 32'd0 : model_mem[model_idx(addr)];
    pend_store = we && !exp_err;
    pend_idx   = pend_store ? model_idx(addr) : 0;
    pend_wdata = wdata;
    pend_be    = be;
    @(negedge clk);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) begin
      check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
      req_valid = 1'b0;
      do_reset();
      return;
    end
    repeat (hold) @(negedge clk);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    busy      = 1'b0;
    rsp_ready = 1'b0;
    if (pend_store) begin
      for (int b = 0; b < 4; b++)
        if (pend_be[b]) model_mem[pend_idx][8*b +: 8] = pend_wdata[8*b +: 8];
      pend_store = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    n_tests    = 0;
    n_fail     = 0;
    busy       = 1'b0;
    due        = 0;
    exp_rdata  = 32'd0;
    exp_err    = 1'b0;
    pend_store = 1'b0;
    chk_en     = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'd0;
    rsp_ready  = 1'b0;

    do_reset();
    chk_en = 1'b1;

    // Model pins.
    check("pin_idx_last", model_idx(32'h1001_03FC), 32'd255);
    check("pin_err_past", {31'd0, model_err(32'h1001_0400)}, 32'd1);
    check("pin_err_below", {31'd0, model_err(32'h1000_FFFC)}, 32'd1);

    // Reset values.
    @(negedge clk);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Store then load.
    do_req(1'b1, 32'h1001_0008, 32'hCAFE_F00D, 4'hF, 0, rd, er);
    check("st_rdata", rd, 32'd0);
    check("st_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h1001_0008, 32'd0, 4'h0, 0, rd, er);
    check("ld_cafe", rd, 32'hCAFE_F00D);
    check("ld_cafe_err", {31'd0, er}, 32'd0);

    // Byte-enable merge.
    do_req(1'b1, 32'h1001_0010, 32'h1122_3344, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h1001_0010, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    do_req(1'b0, 32'h1001_0010, 32'd0, 4'hF, 0, rd, er);
    check("ld_merge", rd, 32'h11BB_33DD);

    // Range boundaries after reset.
    do_reset();
    do_req(1'b0, 32'h1001_0400, 32'd0, 4'h0, 0, rd, er);
    check("past_end_rdata", rd, 32'd0);
    check("past_end_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h1001_000C, 32'd0, 4'h0, 0, rd, er);
    check("zero_rdata", rd, 32'd0);
    check("zero_err", {31'd0, er}, 32'd0);
    do_req(1'b1, 32'h1000_FFFC, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    check("below_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 32'h1001_03FC, 32'h5A5A_A5A5, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h1001_03FC, 32'd0, 4'h0, 0, rd, er);
    check("last_word", rd, 32'h5A5A_A5A5);
    check("last_word_err", {31'd0, er}, 32'd0);

    // Backpressure on a load response.
    do_req(1'b1, 32'h1001_0010, 32'h0BAD_C0DE, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h1001_0010, 32'd0, 4'h0, 5, rd, er);
    check("held_rdata", rd, 32'h0BAD_C0DE);

    // be=0 store is a no-op.
    do_req(1'b1, 32'h1001_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    do_req(1'b0, 32'h1001_0010, 32'd0, 4'h0, 0, rd, er);
    check("be0_noop", rd, 32'h0BAD_C0DE);

    // Reset during WAIT of a store.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = BASE;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy      = 1'b1;
    due       = edge_n + LAT;
    exp_err   = 1'b0;
    exp_rdata = 32'd0;
    do_reset();
    repeat (5) @(negedge clk);
    do_req(1'b0, BASE, 32'd0, 4'h0, 0, rd, er);
    check("abort_store", rd, 32'd0);

    // Sub-word address.
    do_req(1'b1, BASE, 32'h0000_BEEF, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h1001_0002, 32'd0, 4'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("misalign_rdata", rd, 32'd0);
    check("misalign_err", {31'd0, er}, 32'd1);
`else
    check("unaligned_rdata", rd, 32'h0000_BEEF);
    check("unaligned_err", {31'd0, er}, 32'd0);
`endif
    do_req(1'b1, 32'h1001_0005, 32'h7766_5544, 4'b0110, 0, rd, er);

    // Out-of-range stores, then sweep all words against the model.
    do_req(1'b1, 32'h1000_FFFC, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h1001_0400, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b0, BASE + 32'(i * 4), 32'd0, 4'h0, 0, rd, er);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
